// File: rtl/vga_frame_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_frame_reader
//
// Scan-out side of the video RAM. Generates VGA timing from a pixel-rate
// enable, reads one 32-bit word per displayed pixel of a 256x256 image window
// through RAM port B, and drives RGB, syncs and blank to the DAC. Pixels
// outside the window (but inside the active area) are black.
//
// Optional build macro: TEST_PATTERN_EN
//   When defined, test_mode = 1 replaces the active-area RGB with eight
//   80-pixel-wide vertical colour bars. When undefined, test_mode is ignored.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   pix_en       pixel-rate enable; every register advances only when high
//   address_b    RAM port B word address {row[7:0], col[7:0]}, 0 outside window
//   q_b          RAM port B read data, [23:16]=R [15:8]=G [7:0]=B
//   vga_r/g/b    8-bit colour to the DAC
//   vga_hs       horizontal sync, active-low
//   vga_vs       vertical sync, active-low
//   vga_blank_n  high during the active display area
//   frame_start  one-clk pulse when the counters wrap to (0,0)
//   test_mode    colour-bar select (TEST_PATTERN_EN builds only)
//
// Flow qualification: pix_en is a plain enable, not a handshake. A clk edge
// with pix_en high moves the whole pipeline one pixel; with pix_en low every
// register holds, except frame_start which is a single-clk pulse.
// -----------------------------------------------------------------------------
module vga_frame_reader #(
   parameter int H_ACTIVE     = 640,
   parameter int H_FP         = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BP         = 48,
   parameter int V_ACTIVE     = 480,
   parameter int V_FP         = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BP         = 33,
   parameter int IMG_X0       = 192,
   parameter int IMG_Y0       = 112,
   parameter int READ_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_en,
   output logic [15:0] address_b,
   input  logic [31:0] q_b,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic        frame_start,
   input  logic        test_mode
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int CW      = 12;
   localparam int LAST    = READ_LATENCY - 1;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] X0     = CW'(IMG_X0);
   localparam logic [CW-1:0] Y0     = CW'(IMG_Y0);
   localparam logic [CW-1:0] WIN    = CW'(256);

   logic [CW-1:0] h_cnt, v_cnt;
   logic [CW-1:0] h_off, v_off;
   logic          h_wrap, v_wrap;
   logic          active_raw, hs_raw, vs_raw, img_raw;

   logic [READ_LATENCY-1:0] active_pipe, hs_pipe, vs_pipe, img_pipe;
   logic [23:0]             rgb_next;

   logic unused_ok;
   assign unused_ok = &{1'b0, q_b[31:24], test_mode};

   // ---------------------------------------------------------------------------
   // Raw timing decode from the counters
   // ---------------------------------------------------------------------------
   assign h_wrap     = (h_cnt == H_LAST);
   assign v_wrap     = (v_cnt == V_LAST);
   assign active_raw = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_raw     = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
   assign vs_raw     = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

   // Unsigned offsets: positions left of / above the window wrap to large
   // values, so one "< 256" test covers both edges of the window.
   assign h_off   = h_cnt - X0;
   assign v_off   = v_cnt - Y0;
   assign img_raw = active_raw && (h_off < WIN) && (v_off < WIN);

   // ---------------------------------------------------------------------------
   // Counters, RAM address and frame_start
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         address_b   <= '0;
         frame_start <= 1'b0;
      end else begin
         // Taken straight from the counters, so it leads the pixel pipeline.
         frame_start <= pix_en && h_wrap && v_wrap;
         if (pix_en) begin
            if (h_wrap) begin
               h_cnt <= '0;
               v_cnt <= v_wrap ? '0 : v_cnt + CW'(1);
            end else begin
               h_cnt <= h_cnt + CW'(1);
            end
            address_b <= img_raw ? {v_off[7:0], h_off[7:0]} : 16'h0000;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Alignment pipeline: timing flags wait READ_LATENCY pixels so they meet the
   // RAM data for the same pixel at the output register. Sync stages reset to
   // the inactive (high) level so no sync glitch follows reset.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active_pipe <= '0;
         hs_pipe     <= '1;
         vs_pipe     <= '1;
         img_pipe    <= '0;
      end else if (pix_en) begin
         active_pipe[0] <= active_raw;
         hs_pipe[0]     <= hs_raw;
         vs_pipe[0]     <= vs_raw;
         img_pipe[0]    <= img_raw;
         for (int i = 1; i < READ_LATENCY; i++) begin
            active_pipe[i] <= active_pipe[i-1];
            hs_pipe[i]     <= hs_pipe[i-1];
            vs_pipe[i]     <= vs_pipe[i-1];
            img_pipe[i]    <= img_pipe[i-1];
         end
      end
   end

`ifdef TEST_PATTERN_EN
   // Bar colour {R,G,B} from the bar index: the white..black sequence is the
   // bitwise inverse of index bits {1,2,0}.
   logic [CW-1:0] bar_idx;
   logic [2:0]    bar_raw;
   logic [2:0]    bar_pipe [READ_LATENCY];
   logic [READ_LATENCY-1:0] tm_pipe;
   logic          unused_bar;

   assign bar_idx    = h_cnt / CW'(80);
   assign bar_raw    = {~bar_idx[1], ~bar_idx[2], ~bar_idx[0]};
   assign unused_bar = &{1'b0, bar_idx[CW-1:3]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tm_pipe <= '0;
         for (int i = 0; i < READ_LATENCY; i++) bar_pipe[i] <= 3'b000;
      end else if (pix_en) begin
         tm_pipe[0]  <= test_mode;
         bar_pipe[0] <= bar_raw;
         for (int i = 1; i < READ_LATENCY; i++) begin
            tm_pipe[i]  <= tm_pipe[i-1];
            bar_pipe[i] <= bar_pipe[i-1];
         end
      end
   end
`endif

   always_comb begin
      rgb_next = 24'h000000;
      if (img_pipe[LAST]) rgb_next = q_b[23:0];
`ifdef TEST_PATTERN_EN
      if (tm_pipe[LAST] && active_pipe[LAST])
         rgb_next = {{8{bar_pipe[LAST][2]}}, {8{bar_pipe[LAST][1]}}, {8{bar_pipe[LAST][0]}}};
`endif
   end

   // ---------------------------------------------------------------------------
   // Output register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vga_r       <= 8'h00;
         vga_g       <= 8'h00;
         vga_b       <= 8'h00;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
      end else if (pix_en) begin
         vga_r       <= rgb_next[23:16];
         vga_g       <= rgb_next[15:8];
         vga_b       <= rgb_next[7:0];
         vga_hs      <= hs_pipe[LAST];
         vga_vs      <= vs_pipe[LAST];
         vga_blank_n <= active_pipe[LAST];
      end
   end

endmodule

// File: tb/tb_vga_frame_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_vga_frame_reader
//
// Main DUT runs a shrunken geometry (316x12 pixel frame) so several complete
// frames fit in a short run; the 256-wide window still fits inside it. A
// second, default-geometry instance checks the first two 800-pixel lines.
// Expected outputs come from a position-based model: pixel number n after
// reset maps to (n % H_TOTAL, n / H_TOTAL % V_TOTAL), and the pins show that
// pixel READ_LATENCY+1 pix_en pulses later (modelled by a delay queue).
// -----------------------------------------------------------------------------
module tb_vga_frame_reader;

   localparam int HA = 300, HF = 4, HSY = 6, HB = 6;
   localparam int VA = 8,   VF = 1, VSY = 2, VB = 1;
   localparam int X0 = 20,  Y0 = 3, RL = 2;
   localparam int HT = HA + HF + HSY + HB;
   localparam int VT = VA + VF + VSY + VB;
   localparam int FRAME = HT * VT;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, pix_en, test_mode;
   logic [31:0] q_b = 32'h0;
   logic [15:0] address_b;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_blank_n, frame_start;

   vga_frame_reader #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .IMG_X0(X0), .IMG_Y0(Y0), .READ_LATENCY(RL)
   ) dut (
      .clk(clk), .reset(rst_n), .pix_en(pix_en),
      .address_b(address_b), .q_b(q_b),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
      .frame_start(frame_start), .test_mode(test_mode)
   );

   // Port B RAM, one register stage: data for an address is valid at the
   // second pix_en edge after the address changes. Top byte is junk.
   always @(posedge clk) begin
      if (pix_en) q_b <= {8'($urandom), address_b, 8'h5A};
   end

   // Default-geometry instance, pix_en stuck high, all-ones RAM data.
   logic        rst_d;
   logic        pix_en_d = 1'b1;
   logic        test_mode_d = 1'b0;
   logic [31:0] q_b_d = 32'hFFFF_FFFF;
   logic [15:0] address_d;
   logic [7:0]  r_d, g_d, b_d;
   logic        hs_d, vs_d, blank_d, fs_d;

   vga_frame_reader dut_d (
      .clk(clk), .reset(rst_d), .pix_en(pix_en_d),
      .address_b(address_d), .q_b(q_b_d),
      .vga_r(r_d), .vga_g(g_d), .vga_b(b_d),
      .vga_hs(hs_d), .vga_vs(vs_d), .vga_blank_n(blank_d),
      .frame_start(fs_d), .test_mode(test_mode_d)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   int total = 0;
   int bad   = 0;
   int n     = 0;              // pix_en pulses since reset release
   logic [26:0] exp_q[$];      // {hs, vs, blank_n, rgb} per pixel, in flight
   logic [26:0] cur;           // what the pins should show now
   logic [15:0] exp_addr;
   logic        exp_fs;
   logic        mon_done = 1'b0;

`ifdef TEST_PATTERN_EN
   localparam logic [23:0] BAR_COLOUR [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at pulse %0d: got=%h expected=%h", tag, n, got, exp);
      end
   endtask

   function automatic logic [26:0] reset_pins();
      return {1'b1, 1'b1, 1'b0, 24'h000000};
   endfunction

   function automatic logic in_window(int h, int v);
      return (h < HA) && (v < VA) && (h >= X0) && (h < X0 + 256) && (v >= Y0) && (v < Y0 + 256);
   endfunction

   function automatic logic [15:0] addr_for(int p);
      int h, v;
      h = p % HT;
      v = (p / HT) % VT;
      return in_window(h, v) ? {8'(v - Y0), 8'(h - X0)} : 16'h0000;
   endfunction

   function automatic logic [26:0] pins_for(int p, logic tm);
      int h, v;
      logic act, hs, vs;
      logic [23:0] rgb;
      h   = p % HT;
      v   = (p / HT) % VT;
      act = (h < HA) && (v < VA);
      hs  = !((h >= HA + HF) && (h < HA + HF + HSY));
      vs  = !((v >= VA + VF) && (v < VA + VF + VSY));
      rgb = in_window(h, v) ? {8'(v - Y0), 8'(h - X0), 8'h5A} : 24'h000000;
`ifdef TEST_PATTERN_EN
      if (tm && act) rgb = BAR_COLOUR[(h / 80) % 8];
`else
      if (tm && act) rgb = rgb;  // test_mode has no effect without the bars
`endif
      return {hs, vs, act, rgb};
   endfunction

   task automatic compare_all();
      check("vga_hs",      32'(vga_hs),      32'(cur[26]));
      check("vga_vs",      32'(vga_vs),      32'(cur[25]));
      check("vga_blank_n", 32'(vga_blank_n), 32'(cur[24]));
      check("vga_r",       32'(vga_r),       32'(cur[23:16]));
      check("vga_g",       32'(vga_g),       32'(cur[15:8]));
      check("vga_b",       32'(vga_b),       32'(cur[7:0]));
      check("address_b",   32'(address_b),   32'(exp_addr));
      check("frame_start", 32'(frame_start), 32'(exp_fs));
   endtask

   task automatic model_reset();
      n = 0;
      exp_q.delete();
      cur      = reset_pins();
      exp_addr = 16'h0000;
      exp_fs   = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Driver: one clk with the given pix_en, then check the pins
   // ---------------------------------------------------------------------------
   task automatic step(input logic en);
      @(negedge clk);
      pix_en    = en;
      test_mode = 1'($urandom_range(0, 1));
      @(posedge clk);
      exp_fs = 1'b0;
      if (en && rst_n) begin
         n++;
         exp_q.push_back(pins_for(n - 1, test_mode));
         if (exp_q.size() > RL) cur = exp_q.pop_front();
         exp_addr = addr_for(n - 1);
         exp_fs   = (n % FRAME == 0);
      end
      #1;
      compare_all();
   endtask

   // ---------------------------------------------------------------------------
   // Default-geometry monitor: first 1600 clks after release (two lines)
   // ---------------------------------------------------------------------------
   initial begin : default_geometry_monitor
      int hs_low, hs_first, blank_hi, blank_first, vs_low, fs_cnt, leak;
      hs_low = 0; hs_first = -1; blank_hi = 0; blank_first = -1;
      vs_low = 0; fs_cnt = 0; leak = 0;
      wait (rst_d === 1'b1);
      for (int k = 1; k <= 1600; k++) begin
         @(posedge clk);
         #1;
         if (!hs_d) begin
            hs_low++;
            if (hs_first < 0) hs_first = k;
         end
         if (blank_d) begin
            blank_hi++;
            if (blank_first < 0) blank_first = k;
         end
         if (!vs_d) vs_low++;
         if (fs_d)  fs_cnt++;
         if (address_d != 16'h0 || {r_d, g_d, b_d} != 24'h0) leak++;
      end
      check("d_hs_low_clks",   32'(hs_low),      32'd192);
      check("d_hs_first_low",  32'(hs_first),    32'd659);
      check("d_blank_hi_clks", 32'(blank_hi),    32'd1280);
      check("d_blank_first",   32'(blank_first), 32'd3);
      check("d_vs_low_clks",   32'(vs_low),      32'd0);
      check("d_frame_start",   32'(fs_cnt),      32'd0);
      check("d_window_leak",   32'(leak),        32'd0);
      mon_done = 1'b1;
   end

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      rst_n     = 1'b0;
      rst_d     = 1'b0;
      pix_en    = 1'b0;
      test_mode = 1'b0;
      model_reset();

      // Reset state, with pix_en both low and high
      repeat (2) step(1'b0);
      repeat (2) step(1'b1);
      @(negedge clk);
      pix_en = 1'b0;
      rst_n  = 1'b1;
      rst_d  = 1'b1;

      // pix_en continuously high: two full frames and a bit
      repeat (2 * FRAME + 500) step(1'b1);

      // pix_en every other clk
      repeat (FRAME + 400) begin
         step(1'b1);
         step(1'b0);
      end

      // random pix_en
      repeat (6000) step(1'($urandom_range(0, 1)));

      // Reset asserted mid-frame at pixel (150,5)
      while ((n % FRAME) != 5 * HT + 150) step(1'b1);
      @(negedge clk);
      pix_en = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      repeat (3) step(1'b1);
      @(negedge clk);
      pix_en = 1'b0;
      rst_n  = 1'b1;

      // Fresh frame from (0,0); frame_start only after a full frame
      repeat (FRAME + 300) step(1'b1);

      repeat (2000) if (!mon_done) @(posedge clk);
      check("monitor_done", 32'(mon_done), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Scan-out end of the video RAM path. The ARM core writes the frame buffer through port A of ram_2port; this block reads it through port B.
- Generates 640x480@60 VGA timing from a pixel-rate enable.
- Fetches one 32-bit word per displayed pixel for a 256x256 image window and drives RGB, syncs and blank to the DAC. Pixels outside the window are black.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- IMG_X0, 192, first visible column of the image window
- IMG_Y0, 112, first visible line of the image window
- READ_LATENCY, 2, pix_en periods from address_b change to valid q_b (1..4)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel-rate enable; all state advances only when high
- address_b  out  16  RAM port B word address
- q_b  in  32  RAM port B read data; bits [23:16]=R, [15:8]=G, [7:0]=B, [31:24] ignored
- vga_r  out  8  red
- vga_g  out  8  green
- vga_b  out  8  blue
- vga_hs  out  1  horizontal sync, active-low
- vga_vs  out  1  vertical sync, active-low
- vga_blank_n  out  1  high during the active display area
- frame_start  out  1  one-clk pulse at the start of each frame
- test_mode  in  1  colour-bar select; used only with TEST_PATTERN_EN

Behaviour:
- Reset state (asynchronous, reset low):
  - h_cnt = 0, v_cnt = 0, all pipeline stages cleared.
  - address_b = 0; vga_r/g/b = 0; vga_hs = 1; vga_vs = 1; vga_blank_n = 0; frame_start = 0.
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - On pix_en, h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 after V_TOTAL-1, on the same edge as the h_cnt wrap.
- Raw timing, decoded from the counters:
  - active = h_cnt < H_ACTIVE && v_cnt < V_ACTIVE.
  - hs_raw low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw low for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for the whole line.
  - in_img = active && h_cnt-IMG_X0 < 256 && v_cnt-IMG_Y0 < 256, compared unsigned.
- Address generation:
  - Registered on pix_en.
  - If in_img, address_b = {v_cnt-IMG_Y0 [7:0], h_cnt-IMG_X0 [7:0]}; otherwise address_b = 0.
  - address_b is held between pix_en pulses.
- Alignment pipeline:
  - active, hs_raw, vs_raw and in_img pass through READ_LATENCY stages, shifting on pix_en.
  - Output register, updated on pix_en:
    - vga_hs/vga_vs/vga_blank_n take the last stage.
    - RGB = q_b fields if delayed in_img, else 0.
  - Total latency from counter value to pins = READ_LATENCY+1 pix_en periods. All outputs share that latency, so sync and pixel stay aligned.
- frame_start:
  - Asserted for exactly one clk, on the clk edge where pix_en is high and the counters wrap from (799,524) to (0,0).
  - Not delayed by the pipeline.
- pix_en low:
  - Every register holds its value.
  - pix_en stuck high gives one pixel per clk, which is legal.
- Reset mid-frame: everything returns to its reset values immediately. The first post-reset frame starts at (0,0). No partial frame_start is emitted.
- The block never writes RAM, so it needs no coordination with port A. Tearing is acceptable.

Optional Feature:
- Macro: TEST_PATTERN_EN.
- With the macro defined and test_mode = 1:
  - RGB in the active area are 8 vertical colour bars, each 80 pixels wide: white, yellow, cyan, green, magenta, red, blue, black.
  - Each channel is 8'hFF or 8'h00.
  - Bar colours have the same latency and alignment as RAM pixels.
  - address_b keeps generating normally.
  - test_mode is sampled on pix_en.
- Without the macro: test_mode is ignored, no bar logic is synthesized, and output is RAM/black only.

Test Plan:
- Reset released, pix_en = 1 continuously:
  - first frame_start after 420000 clks.
  - vga_hs low for 96 clks every 800.
  - vga_vs low for 1600 clks every 420000.
  - vga_blank_n high for 640 clks per visible line.
- RAM model with READ_LATENCY=2, word(addr) = {8'h0, addr[15:8], addr[7:0], 8'h5A}:
  - pixel at screen (192,112) shows R=00 G=00 B=5A.
  - pixel at (447,367) shows R=FF G=FF B=5A.
  - pixel at (191,112) shows 0.
  - pixel at (448,112) shows 0.
- Check address_b = 16'h0100 when h_cnt=192, v_cnt=113. Check address_b = 0 while h_cnt >= 640.
- pix_en toggling every other clk:
  - same pixel values as the continuous-pix_en case.
  - all periods doubled (hsync low 192 clks).
  - outputs stable on clks with pix_en low.
- Assert reset at (300,200) for 3 clks:
  - outputs go to reset values within the same clk.
  - counters restart at (0,0).
  - no frame_start until 420000 pix_en after release.
- TEST_PATTERN_EN defined, test_mode=1: x=0..79 gives FF/FF/FF; x=80 gives FF/FF/00; x=560 gives 00/00/00; blanking gives 0.
